div_32: RTL and testbench



---
 rtl/div_pkg.sv | 15 +
 rtl/div_sub_33.sv | 14 +
 rtl/div_32.sv | 164 ++++++++++++++++
 tb/tb_div_32.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

  localparam int unsigned DIV_WIDTH     = 32;
  localparam int unsigned DIV_ITER      = 32;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_sub_33.sv
// Combinational trial subtractor; borrow is the sign bit of the difference.
module div_sub_33 #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_borrow
);

  assign o_diff   = i_a - i_b;
  assign o_borrow = o_diff[W-1];

endmodule

// File: rtl/div_32.sv
// Multi-cycle restoring divider (DIVU, plus DIV when DIV_SIGNED_EN is defined).
// Start/busy/done handshake; results registered and held until the next result.
module div_32
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  div_state_t       r_state;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [5:0]       r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remd;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_unused;

`ifdef DIV_SIGNED_EN
  logic r_sgn;
  logic r_neg_q;
  logic r_neg_r;

  assign w_a_mag  = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_b_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign w_unused = r_rem[WIDTH];
`else
  assign w_a_mag  = dividend;
  assign w_b_mag  = divisor;
  assign w_unused = ^{is_signed, r_rem[WIDTH]};
`endif

  assign w_shift   = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_rem_nxt = w_borrow ? w_shift : w_trial;
  assign w_q_nxt   = {r_q[WIDTH-2:0], ~w_borrow};

  div_sub_33 #(.W(WIDTH + 1)) u_sub (
    .i_a      (w_shift),
    .i_b      ({1'b0, r_d}),
    .o_diff   (w_trial),
    .o_borrow (w_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DIV_IDLE;
      r_rem   <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_quot  <= '0;
      r_remd  <= '0;
`ifdef DIV_SIGNED_EN
      r_sgn   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        DIV_IDLE, DIV_DONE: begin
          if (start) begin
            r_rem <= '0;
            r_q   <= w_a_mag;
            r_d   <= w_b_mag;
            r_cnt <= '0;
`ifdef DIV_SIGNED_EN
            r_sgn   <= is_signed;
            r_neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_r <= is_signed & dividend[WIDTH-1];
`endif
            // Zero divisor skips the iteration and reports the raw dividend.
            if (divisor == '0) begin
              r_state <= DIV_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_quot  <= DIV_ZERO_QUOT;
              r_remd  <= dividend;
              r_dz    <= 1'b1;
            end else begin
              r_state <= DIV_CALC;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= DIV_IDLE;
            r_busy  <= 1'b0;
          end
        end
        DIV_CALC: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'(DIV_ITER - 1)) begin
`ifdef DIV_SIGNED_EN
            if (r_sgn) begin
              r_state <= DIV_FIX;
            end else begin
              r_state <= DIV_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_quot  <= w_q_nxt;
              r_remd  <= w_rem_nxt[WIDTH-1:0];
              r_dz    <= 1'b0;
            end
`else
            r_state <= DIV_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quot  <= w_q_nxt;
            r_remd  <= w_rem_nxt[WIDTH-1:0];
            r_dz    <= 1'b0;
`endif
          end
        end
`ifdef DIV_SIGNED_EN
        DIV_FIX: begin
          r_state <= DIV_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_quot  <= r_neg_q ? -r_q : r_q;
          r_remd  <= r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
          r_dz    <= 1'b0;
        end
`endif
        default: begin
          r_state <= DIV_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_remd;
  assign div_zero  = r_dz;

endmodule

// File: tb/tb_div_32.sv
// Scoreboard bench for div_32: expectations queued at launch, checked on done.
// Signed-result expectations follow DIV_SIGNED_EN when it is defined.
module tb_div_32;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    int          nbusy;
  } exp_t;

  exp_t  sb[$];
  string tag_q[$];

  div_32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] q, input logic [31:0] r,
                          input logic dz, input int lat, input int nbusy);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.lat = lat; e.nbusy = nbusy;
    sb.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Reference unsigned model built on the language's own / and % operators.
  task automatic push_u(input string tag, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) push_exp(tag, 32'hFFFF_FFFF, a, 1'b1, 1, 0);
    else            push_exp(tag, a / b, a % b, 1'b0, 33, 32);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge of cycle 1 after accept. arm_mode: 0 none, 1 start pulse, 2 start held.
  task automatic wait_result(input int arm_mode, input int arm_cyc,
                             input logic [31:0] arm_a, input logic [31:0] arm_b);
    int   cyc = 1;
    int   nbusy = 0;
    bit   got = 0;
    exp_t e;
    string tag;
    while (cyc <= 40) begin
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) begin got = 1; break; end
      if (arm_mode != 0 && cyc == arm_cyc) begin
        start = 1'b1; dividend = arm_a; divisor = arm_b; is_signed = 1'b0;
      end
      if (arm_mode == 1 && cyc == arm_cyc + 1) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    tag = tag_q.pop_front();
    if (!got) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_quot"}, quotient, e.q);
      chk({tag, "_rem"}, remainder, e.r);
      chk({tag, "_dz"}, {31'd0, div_zero}, {31'd0, e.dz});
      chk({tag, "_lat"}, cyc, e.lat);
      chk({tag, "_busycyc"}, nbusy, e.nbusy);
      chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int ndone;

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);
    chk("rst_quot", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);
    rst_n = 1'b1;

    push_u("u100_7", 32'd100, 32'd7);
    drive(32'd100, 32'd7, 1'b0);
    wait_result(0, 0, '0, '0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("held_quot", quotient, 32'd14);

    push_u("umax_1", 32'hFFFF_FFFF, 32'd1);
    drive(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_result(0, 0, '0, '0);

    push_u("u3_msb", 32'd3, 32'h8000_0000);
    drive(32'd3, 32'h8000_0000, 1'b0);
    wait_result(0, 0, '0, '0);

    push_u("divzero", 32'd5, 32'd0);
    drive(32'd5, 32'd0, 1'b0);
    wait_result(0, 0, '0, '0);

`ifdef DIV_SIGNED_EN
    push_exp("s_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 33);
    drive(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_result(0, 0, '0, '0);
    push_exp("s_ovf", 32'h8000_0000, 32'd0, 1'b0, 34, 33);
    drive(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_result(0, 0, '0, '0);
`else
    push_u("nosign_m7_2", 32'hFFFF_FFF9, 32'd2);
    drive(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_result(0, 0, '0, '0);
    push_u("nosign_ovf", 32'h8000_0000, 32'hFFFF_FFFF);
    drive(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_result(0, 0, '0, '0);
`endif

    push_u("restart_ign", 32'd1000, 32'd3);
    drive(32'd1000, 32'd3, 1'b0);
    wait_result(1, 10, 32'd50, 32'd5);

    push_u("b2b_a", 32'hDEAD_BEEF, 32'h0000_1234);
    drive(32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
    wait_result(2, 32, 32'h1234_5678, 32'h0000_0010);
    push_u("b2b_b", 32'h1234_5678, 32'h0000_0010);
    @(negedge clk);
    start = 1'b0;
    wait_result(0, 0, '0, '0);

    push_u("aborted", 32'd100, 32'd7);
    drive(32'd100, 32'd7, 1'b0);
    for (int c = 1; c < 15; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quot", quotient, 32'd0);
    chk("abort_rem", remainder, 32'd0);
    chk("abort_dz", {31'd0, div_zero}, 32'd0);
    chk("abort_state", 32'(dut.r_state), 32'(DIV_IDLE));
    void'(sb.pop_front());
    void'(tag_q.pop_front());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);

    push_u("u81_9", 32'd81, 32'd9);
    drive(32'd81, 32'd9, 1'b0);
    wait_result(0, 0, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
